// File: rtl/m_cache_refill_pkg.sv
// Shared definitions for the cache line-fill engine: address geometry and refill FSM states.
package m_cache_refill_pkg;

    localparam int unsigned ADDR_WIDTH      = 32;
    localparam int unsigned LINE_OFS_WIDTH  = 4;
    localparam int unsigned LINE_WORDS      = 4;
    localparam int unsigned WORD_WIDTH      = 32;
    localparam int unsigned LINE_WIDTH      = LINE_WORDS * WORD_WIDTH;
    localparam int unsigned LINE_ADDR_WIDTH = ADDR_WIDTH - LINE_OFS_WIDTH;

    typedef enum logic [2:0] {
        RF_IDLE,
        RF_FETCH,
        RF_WAIT,
        RF_INSTALL,
        RF_DONE
    } rf_state_e;

endpackage

// File: rtl/m_cache_refill.sv
// Line-fill engine: fetches a 4-word line with single-word reads and installs it into the cache.
// Optional critical-word-first ordering and early restart are enabled by defining CACHE_REFILL_CWF_EN.
module m_cache_refill
    import m_cache_refill_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_miss,
    input  logic [ADDR_WIDTH-1:0]   i_miss_addr,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_mem_req,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    input  logic                    i_mem_ack,
    input  logic                    i_mem_rvalid,
    input  logic [WORD_WIDTH-1:0]   i_mem_rdata,
    output logic                    o_bwe,
    output logic [ADDR_WIDTH-1:0]   o_waddr,
    output logic [LINE_WIDTH-1:0]   o_bdata,
    output logic                    o_cw_valid,
    output logic [WORD_WIDTH-1:0]   o_cw_data
);

    localparam logic [1:0] MAX_OUT    = 2'(MAX_OUTSTANDING);
    localparam logic [2:0] BEATS      = 3'(LINE_WORDS);
    localparam logic [1:0] LAST_BEAT  = 2'(LINE_WORDS - 1);

    rf_state_e                  state_q, state_d;
    logic [LINE_ADDR_WIDTH-1:0] line_q, line_d;
    logic [2:0]                 issued_q, issued_d;
    logic [1:0]                 outstanding_q, outstanding_d;
    logic [1:0]                 rcvd_q, rcvd_d;
    logic [LINE_WIDTH-1:0]      bdata_q, bdata_d;

    logic       mem_req;
    logic       issue;
    logic       accept;
    logic [1:0] beat_base;
    logic [1:0] issue_beat;
    logic [1:0] resp_beat;

`ifdef CACHE_REFILL_CWF_EN
    logic [1:0] widx_q, widx_d;
    logic [1:0] addr_lsb_unused;

    assign addr_lsb_unused = i_miss_addr[1:0];
    assign beat_base       = widx_q;
`else
    logic [3:0] addr_lsb_unused;

    assign addr_lsb_unused = i_miss_addr[3:0];
    assign beat_base       = '0;
`endif

    assign issue_beat = beat_base + issued_q[1:0];
    assign resp_beat  = beat_base + rcvd_q;

    assign mem_req = (state_q == RF_FETCH) && (issued_q < BEATS) && (outstanding_q < MAX_OUT);
    assign issue   = mem_req && i_mem_ack;
    // A response with nothing outstanding is out of protocol and is dropped; this also
    // makes a 4th response while still fetching unreachable.
    assign accept  = ((state_q == RF_FETCH) || (state_q == RF_WAIT)) && i_mem_rvalid
                     && (outstanding_q != '0);

    always_comb begin
        state_d       = state_q;
        line_d        = line_q;
        issued_d      = issued_q;
        outstanding_d = outstanding_q;
        rcvd_d        = rcvd_q;
        bdata_d       = bdata_q;
`ifdef CACHE_REFILL_CWF_EN
        widx_d        = widx_q;
`endif

        unique case (state_q)
            RF_IDLE: begin
                if (i_miss) begin
                    line_d        = i_miss_addr[ADDR_WIDTH-1:LINE_OFS_WIDTH];
                    issued_d      = '0;
                    outstanding_d = '0;
                    rcvd_d        = '0;
`ifdef CACHE_REFILL_CWF_EN
                    widx_d        = i_miss_addr[3:2];
`endif
                    state_d       = RF_FETCH;
                end
            end
            RF_FETCH: begin
                if (issue && (issued_q[1:0] == LAST_BEAT)) begin
                    state_d = RF_WAIT;
                end
            end
            RF_WAIT: begin
                if (accept && (rcvd_q == LAST_BEAT)) begin
                    state_d = RF_INSTALL;
                end
            end
            RF_INSTALL: state_d = RF_DONE;
            RF_DONE:    state_d = RF_IDLE;
            default:    state_d = RF_IDLE;
        endcase

        if (issue) begin
            issued_d = issued_q + 3'd1;
        end

        unique case ({issue, accept})
            2'b10:   outstanding_d = outstanding_q + 2'd1;
            2'b01:   outstanding_d = outstanding_q - 2'd1;
            default: outstanding_d = outstanding_q;
        endcase

        if (accept) begin
            bdata_d[{resp_beat, 5'd0} +: WORD_WIDTH] = i_mem_rdata;
            rcvd_d = rcvd_q + 2'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= RF_IDLE;
            line_q        <= '0;
            issued_q      <= '0;
            outstanding_q <= '0;
            rcvd_q        <= '0;
            bdata_q       <= '0;
`ifdef CACHE_REFILL_CWF_EN
            widx_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            line_q        <= line_d;
            issued_q      <= issued_d;
            outstanding_q <= outstanding_d;
            rcvd_q        <= rcvd_d;
            bdata_q       <= bdata_d;
`ifdef CACHE_REFILL_CWF_EN
            widx_q        <= widx_d;
`endif
        end
    end

    assign o_busy     = (state_q != RF_IDLE);
    assign o_done     = (state_q == RF_DONE);
    assign o_bwe      = (state_q == RF_INSTALL);
    assign o_mem_req  = mem_req;
    assign o_mem_addr = {line_q, issue_beat, 2'b00};
    assign o_waddr    = {line_q, {LINE_OFS_WIDTH{1'b0}}};
    assign o_bdata    = bdata_q;

`ifdef CACHE_REFILL_CWF_EN
    // The first accepted response is always the critical word; forward it combinationally.
    assign o_cw_valid = accept && (rcvd_q == '0);
    assign o_cw_data  = (accept && (rcvd_q == '0)) ? i_mem_rdata : '0;
`else
    assign o_cw_valid = 1'b0;
    assign o_cw_data  = '0;
`endif

endmodule
